// File: rtl/bits_pack.sv
// bits_pack: packs 1-16 bit fields MSB-first into 32-bit words, queued through a
// small output FIFO; a flush emits the partial word left-aligned with its bit count.
module bits_pack #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pushin,
    input  logic [15:0] datain,
    input  logic [4:0]  lenin,
    input  logic        flushin,
    output logic        stopout,
    input  logic        stopin,
    output logic        pushout,
    output logic [31:0] dataout,
    output logic [5:0]  lenout
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   r_acc;
    logic [5:0]    r_cnt;
    logic          r_flush_pend;
    logic [31:0]   r_fdata [DEPTH];
    logic [5:0]    r_flen  [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [4:0]    w_len;
    logic [5:0]    w_tot;
    logic [31:0]   w_fal, w_join, w_wdata;
    logic [5:0]    w_wlen;
    logic          w_push, w_exec, w_wr, w_rd;
    assign w_len   = (lenin > 5'd16) ? 5'd16 : lenin;
    assign stopout = (r_count == (AW+1)'(DEPTH));
    assign w_push  = pushin & ~stopout & (lenin != 5'd0);
    assign w_tot   = r_cnt + {1'b0, w_len};
    // field left-aligned in 32 bits, everything below it zero
    assign w_fal   = {datain, 16'h0} << (5'd16 - w_len);
    assign w_join  = r_acc | (w_fal >> r_cnt);
    assign w_exec  = r_flush_pend & ~w_push & ~stopout;
    assign w_wr    = (w_push & w_tot[5]) | (w_exec & (r_cnt != 6'd0));
    assign w_wdata = w_push ? w_join : r_acc;
    assign w_wlen  = w_push ? 6'd32 : r_cnt;
    assign w_rd    = (r_count != '0) & ~stopin;
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            pushout      <= 1'b0;
            dataout      <= '0;
            lenout       <= '0;
        end else begin
            if (w_push) begin
                // on a full word the leftover field bits shift up to the top of acc
                r_acc <= w_tot[5] ? (w_fal << (6'd32 - r_cnt)) : w_join;
                r_cnt <= w_tot[5] ? (w_tot - 6'd32) : w_tot;
            end else if (w_exec) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
            r_flush_pend <= (flushin & ~stopout) | (r_flush_pend & ~w_exec);
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            pushout <= w_rd;
            if (w_rd) begin
                dataout <= r_fdata[r_rptr];
                lenout  <= r_flen[r_rptr];
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset && w_wr) begin
            r_fdata[r_wptr] <= w_wdata;
            r_flen[r_wptr]  <= w_wlen;
        end
    end
endmodule

// File: tb/tb_bits_pack.sv
// tb_bits_pack: directed and random checks of bits_pack against a bit-queue model
// of the packer and a word-queue model of the output FIFO.
module tb_bits_pack;
    localparam int DEPTH = 4;
    logic        clock = 0, reset = 0, pushin = 0, flushin = 0, stopin = 0;
    logic [15:0] datain = 0;
    logic [4:0]  lenin = 0;
    logic        stopout, pushout;
    logic [31:0] dataout;
    logic [5:0]  lenout;
    int          n_chk = 0, n_fail = 0;
    bit          mbits[$];
    logic [37:0] mq[$], exp_out[$], got[$];
    bit          m_pend = 0, m_exp_push = 0;
    logic [37:0] m_exp_word;

    bits_pack #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .pushin(pushin), .datain(datain), .lenin(lenin),
        .flushin(flushin), .stopout(stopout), .stopin(stopin), .pushout(pushout),
        .dataout(dataout), .lenout(lenout)
    );

    always #5 clock = ~clock;

    // one clock of stimulus; the model runs on pre-edge state, the DUT is sampled 1 after the edge
    task automatic step(input bit p, input logic [15:0] d, input int l, input bit f, input bit s, output bit acc);
        int len, n;
        bit m_stop, exec;
        logic [31:0] w;
        pushin = p; datain = d; lenin = 5'(l); flushin = f; stopin = s;
        m_stop = (mq.size() == DEPTH);
        len = (l > 16) ? 16 : l;
        acc = p && !m_stop && len != 0;
        exec = m_pend && !acc && !m_stop;
        m_exp_push = (mq.size() > 0) && !s;
        if (m_exp_push) begin
            m_exp_word = mq.pop_front();
            exp_out.push_back(m_exp_word);
        end
        if (acc) begin
            for (int b = len - 1; b >= 0; b--) mbits.push_back(d[b]);
            if (mbits.size() >= 32) begin
                w = 0;
                for (int i = 0; i < 32; i++) w = {w[30:0], mbits.pop_front()};
                mq.push_back({w, 6'd32});
            end
        end
        if (exec && mbits.size() > 0) begin
            n = mbits.size();
            w = 0;
            for (int i = 0; i < 32; i++) w = {w[30:0], (i < n) ? mbits[i] : 1'b0};
            mq.push_back({w, 6'(n)});
            mbits.delete();
        end
        m_pend = (f && !m_stop) || (m_pend && !exec);
        @(posedge clock); #1;
        if (pushout) got.push_back({dataout, lenout});
    endtask

    task automatic idle(input int n, input bit s);
        bit a;
        repeat (n) step(0, 16'h0, 0, 0, s, a);
    endtask

    task automatic apply_reset();
        reset = 0; pushin = 0; flushin = 0; stopin = 0; lenin = 0; datain = 0;
        @(posedge clock); #1;
        reset = 1;
        mbits.delete(); mq.delete(); exp_out.delete(); got.delete();
        m_pend = 0; m_exp_push = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk += 4;
        if (pushout !== 1'b0) begin n_fail++; $display("FAIL reset_pushout: got %b expected 0", pushout); end
        if (dataout !== 32'h0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
        if (lenout !== 6'd0) begin n_fail++; $display("FAIL reset_lenout: got %0d expected 0", lenout); end
        if (stopout !== 1'b0) begin n_fail++; $display("FAIL reset_stopout: got %b expected 0", stopout); end
    endtask

    task automatic test_nibbles();
        bit a;
        apply_reset();
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 4, 0, 0, a);
        n_chk++;
        if (pushout !== 1'b0) begin n_fail++; $display("FAIL nib_early: pushout %b expected 0", pushout); end
        idle(1, 0);
        n_chk += 2;
        if (pushout !== 1'b1) begin n_fail++; $display("FAIL nib_latency: pushout %b expected 1", pushout); end
        if ({dataout, lenout} !== {32'h12345678, 6'd32}) begin
            n_fail++; $display("FAIL nib_word: got %h/%0d expected 12345678/32", dataout, lenout);
        end
        idle(4, 0);
        n_chk += 2;
        if (got.size() != 1) begin n_fail++; $display("FAIL nib_count: got %0d words expected 1", got.size()); end
        if (dataout !== 32'h12345678) begin n_fail++; $display("FAIL nib_hold: dataout %h expected 12345678", dataout); end
    endtask

    task automatic test_flush(input bit same_cycle);
        bit a;
        apply_reset();
        step(1, 16'h0ABC, 12, 0, 0, a);
        step(1, 16'h0DEF, 12, 0, 0, a);
        step(1, 16'h0123, 12, same_cycle, 0, a);
        if (!same_cycle) step(0, 16'h0, 0, 1, 0, a);
        idle(8, 0);
        n_chk++;
        if (got.size() != 2) begin
            n_fail++; $display("FAIL flush_count(same=%0d): got %0d words expected 2", same_cycle, got.size());
        end else begin
            n_chk += 2;
            if (got[0] !== {32'hABCDEF12, 6'd32}) begin
                n_fail++; $display("FAIL flush_w0(same=%0d): got %h expected %h", same_cycle, got[0], {32'hABCDEF12, 6'd32});
            end
            if (got[1] !== {32'h30000000, 6'd4}) begin
                n_fail++; $display("FAIL flush_w1(same=%0d): got %h expected %h", same_cycle, got[1], {32'h30000000, 6'd4});
            end
        end
    endtask

    task automatic test_backpressure();
        bit a;
        int i, guard;
        logic [31:0] w;
        apply_reset();
        for (int k = 0; k < 32; k++) step(1, 16'(k % 16), 4, 0, 1, a);
        n_chk++;
        if (stopout !== 1'b1) begin n_fail++; $display("FAIL bp_stop_rise: stopout %b expected 1", stopout); end
        step(1, 16'(32 % 16), 4, 0, 1, a);
        n_chk += 2;
        if (stopout !== 1'b1) begin n_fail++; $display("FAIL bp_stop_hold: stopout %b expected 1", stopout); end
        if (got.size() != 0) begin n_fail++; $display("FAIL bp_stalled_out: got %0d words expected 0", got.size()); end
        i = 32; guard = 0;
        while (i < 40 && guard < 100) begin
            step(1, 16'(i % 16), 4, 0, 0, a);
            if (a) i++;
            guard++;
        end
        n_chk++;
        if (i != 40) begin n_fail++; $display("FAIL bp_timeout: accepted %0d fields expected 40", i); end
        idle(12, 0);
        n_chk += 2;
        if (stopout !== 1'b0) begin n_fail++; $display("FAIL bp_stop_fall: stopout %b expected 0", stopout); end
        if (got.size() != 5) begin
            n_fail++; $display("FAIL bp_count: got %0d words expected 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                w = 0;
                for (int j = 0; j < 8; j++) w = {w[27:0], 4'((8 * k + j) % 16)};
                n_chk++;
                if (got[k] !== {w, 6'd32}) begin
                    n_fail++; $display("FAIL bp_word%0d: got %h expected %h", k, got[k], {w, 6'd32});
                end
            end
        end
    endtask

    task automatic test_zero_len();
        bit a;
        apply_reset();
        step(1, 16'hFFFF, 0, 0, 0, a);
        step(1, 16'hFFFF, 0, 0, 0, a);
        step(0, 16'h0, 0, 1, 0, a);
        idle(5, 0);
        n_chk += 2;
        if (got.size() != 0) begin n_fail++; $display("FAIL zl_noout: got %0d words expected 0", got.size()); end
        if (stopout !== 1'b0) begin n_fail++; $display("FAIL zl_stop: stopout %b expected 0", stopout); end
        step(1, 16'hA5C3, 20, 0, 0, a);
        step(1, 16'hFFFF, 0, 0, 0, a);
        step(1, 16'h1234, 16, 0, 0, a);
        idle(5, 0);
        n_chk++;
        if (got.size() != 1) begin
            n_fail++; $display("FAIL zl_count: got %0d words expected 1", got.size());
        end else begin
            n_chk++;
            if (got[0] !== {32'hA5C31234, 6'd32}) begin
                n_fail++; $display("FAIL zl_len20: got %h expected %h", got[0], {32'hA5C31234, 6'd32});
            end
        end
    endtask

    task automatic test_ffff();
        bit a;
        apply_reset();
        step(1, 16'hFFFF, 16, 0, 0, a);
        step(1, 16'h0001, 16, 0, 0, a);
        idle(4, 0);
        step(0, 16'h0, 0, 1, 0, a);
        idle(5, 0);
        n_chk++;
        if (got.size() != 1) begin n_fail++; $display("FAIL ff_count: got %0d words expected 1", got.size()); end
        step(1, 16'h005A, 8, 0, 0, a);
        step(0, 16'h0, 0, 1, 0, a);
        idle(6, 0);
        n_chk++;
        if (got.size() != 2) begin
            n_fail++; $display("FAIL ff_count2: got %0d words expected 2", got.size());
        end else begin
            n_chk += 2;
            if (got[0] !== {32'hFFFF0001, 6'd32}) begin
                n_fail++; $display("FAIL ff_word: got %h expected %h", got[0], {32'hFFFF0001, 6'd32});
            end
            if (got[1] !== {32'h5A000000, 6'd8}) begin
                n_fail++; $display("FAIL ff_cleared: got %h expected %h", got[1], {32'h5A000000, 6'd8});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        apply_reset();
        step(1, 16'hDEAD, 16, 0, 0, a);
        step(1, 16'hBEEF, 16, 0, 0, a);
        idle(4, 0);
        for (int k = 0; k < 4; k++) step(1, 16'(16'h1111 * (k + 1)), 16, 0, 1, a);
        step(1, 16'h03FF, 10, 0, 1, a);
        idle(2, 1);
        n_chk += 2;
        if (got.size() != 1) begin n_fail++; $display("FAIL rm_pre: got %0d words expected 1", got.size()); end
        if (dataout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rm_pre_data: dataout %h expected deadbeef", dataout); end
        apply_reset();
        n_chk += 4;
        if (pushout !== 1'b0) begin n_fail++; $display("FAIL rm_pushout: got %b expected 0", pushout); end
        if (dataout !== 32'h0) begin n_fail++; $display("FAIL rm_dataout: got %h expected 0", dataout); end
        if (lenout !== 6'd0) begin n_fail++; $display("FAIL rm_lenout: got %0d expected 0", lenout); end
        if (stopout !== 1'b0) begin n_fail++; $display("FAIL rm_stopout: got %b expected 0", stopout); end
        step(0, 16'h0, 0, 1, 0, a);
        idle(6, 0);
        n_chk++;
        if (got.size() != 0) begin n_fail++; $display("FAIL rm_flush_empty: got %0d words expected 0", got.size()); end
    endtask

    task automatic test_random();
        bit a;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 20),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, a);
            n_chk += 2;
            if (pushout !== m_exp_push) begin
                n_fail++; $display("FAIL rnd_pushout@%0d: got %b expected %b", c, pushout, m_exp_push);
            end
            if (stopout !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_stopout@%0d: got %b expected %b", c, stopout, mq.size() == DEPTH);
            end
            if (m_exp_push) begin
                n_chk++;
                if ({dataout, lenout} !== m_exp_word) begin
                    n_fail++; $display("FAIL rnd_word@%0d: got %h expected %h", c, {dataout, lenout}, m_exp_word);
                end
            end
        end
        step(0, 16'h0, 0, 1, 0, a);
        idle(12, 0);
        n_chk += 2;
        if (mbits.size() != 0 || mq.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain: model holds %0d bits %0d words expected 0", mbits.size(), mq.size());
        end
        if (got.size() != exp_out.size()) begin
            n_fail++; $display("FAIL rnd_total: got %0d words expected %0d", got.size(), exp_out.size());
        end else begin
            for (int k = 0; k < got.size(); k++) begin
                n_chk++;
                if (got[k] !== exp_out[k]) begin
                    n_fail++; $display("FAIL rnd_seq%0d: got %h expected %h", k, got[k], exp_out[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nibbles();
        test_flush(0);
        test_flush(1);
        test_backpressure();
        test_zero_len();
        test_ffff();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
